// File: rtl/quadrature_encoder_reader.sv
// Quadrature encoder reader.
// Synchronizes and glitch-filters the encoder A/B/index pins, decodes the filtered A/B
// pair into a 16-bit wrapping position count, and measures a saturated signed velocity
// (steps per WINDOW_CYCLES clocks).
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-high reset
//   enc_a, enc_b   encoder channels (asynchronous to clk)
//   enc_i          encoder index pulse (asynchronous to clk)
//   index_enable   an accepted index rising edge zeroes the count when 1
//   clear_error    synchronous clear of quad_error
//   encoder_count  unsigned position count, wraps modulo 65536
//   raw_velocity   signed steps per window, saturated to [-4096, 4095]
//   velocity_valid one-cycle pulse when raw_velocity updates
//   quad_error     sticky illegal-transition flag
module quadrature_encoder_reader #(
  parameter int unsigned FILTER_DEPTH  = 4,
  parameter int unsigned WINDOW_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               enc_i,
  input  logic               index_enable,
  input  logic               clear_error,
  output logic        [15:0] encoder_count,
  output logic signed [12:0] raw_velocity,
  output logic               velocity_valid,
  output logic               quad_error
);

  localparam logic [3:0]  DepthLast = 4'(FILTER_DEPTH - 1);
  localparam logic [15:0] WinLast   = 16'(WINDOW_CYCLES - 1);

  // Bit order everywhere: [0]=A, [1]=B, [2]=index.
  logic [2:0]      pins;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      filt_q, filt_d;
  logic [2:0]      prev_q;
  logic [2:0][3:0] fcnt_q, fcnt_d;

  logic [15:0]        count_q, count_d;
  logic signed [16:0] acc_q, acc_d;
  logic [15:0]        win_q, win_d;
  logic signed [12:0] vel_q, vel_d;
  logic               valid_q;
  logic               err_q, err_d;

  logic [1:0]         pos_now, pos_prev, pos_delta;
  logic               step_fwd, step_rev, illegal, index_fire, terminal;
  logic signed [17:0] step_s, vel_sum;

  assign pins = {enc_i, enc_b, enc_a};

  // A pin's new level is accepted on the cycle its disagreement count would reach
  // FILTER_DEPTH; any agreement in between restarts the count.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == DepthLast) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  // Map {A,B} onto a 2-bit phase so forward motion is +1 mod 4:
  // 00->0, 10->1, 11->2, 01->3. A phase jump of 2 means both pins changed.
  assign pos_now   = {filt_q[1], filt_q[0] ^ filt_q[1]};
  assign pos_prev  = {prev_q[1], prev_q[0] ^ prev_q[1]};
  assign pos_delta = pos_now - pos_prev;
  assign step_fwd  = (pos_delta == 2'd1);
  assign step_rev  = (pos_delta == 2'd3);
  assign illegal   = (pos_delta == 2'd2);

  assign index_fire = index_enable & filt_q[2] & ~prev_q[2];
  assign terminal   = (win_q == WinLast);

  always_comb begin
    if (index_fire) begin
      count_d = '0;
    end else if (step_fwd) begin
      count_d = count_q + 16'd1;
    end else if (step_rev) begin
      count_d = count_q - 16'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Set has priority over clear.
  always_comb begin
    err_d = err_q;
    if (clear_error) err_d = 1'b0;
    if (illegal)     err_d = 1'b1;
  end

  // The terminal cycle's step belongs to the closing window.
  always_comb begin
    step_s  = step_fwd ? 18'sd1 : (step_rev ? -18'sd1 : 18'sd0);
    vel_sum = $signed({acc_q[16], acc_q}) + step_s;
    vel_d   = vel_q;
    win_d   = win_q + 16'd1;
    if (vel_sum > 18'sd65535) begin
      acc_d = 17'sd65535;
    end else if (vel_sum < -18'sd65535) begin
      acc_d = -17'sd65535;
    end else begin
      acc_d = vel_sum[16:0];
    end
    if (terminal) begin
      win_d = '0;
      acc_d = '0;
      if (vel_sum > 18'sd4095) begin
        vel_d = 13'sd4095;
      end else if (vel_sum < -18'sd4096) begin
        vel_d = -13'sd4096;
      end else begin
        vel_d = vel_sum[12:0];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      fcnt_q  <= '0;
      prev_q  <= '0;
      count_q <= '0;
      acc_q   <= '0;
      win_q   <= '0;
      vel_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= pins;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      fcnt_q  <= fcnt_d;
      prev_q  <= filt_q;
      count_q <= count_d;
      acc_q   <= acc_d;
      win_q   <= win_d;
      vel_q   <= vel_d;
      valid_q <= terminal;
      err_q   <= err_d;
    end
  end

  assign encoder_count  = count_q;
  assign raw_velocity   = vel_q;
  assign velocity_valid = valid_q;
  assign quad_error     = err_q;

endmodule

// File: doc/quadrature_encoder_reader.md
Name: quadrature_encoder_reader

Overview:
- Decodes the motor's incremental quadrature encoder (A/B/index) into the 16-bit position count (`encoder_count`) that feeds commutation modulo reduction.
- Produces the 13-bit signed windowed velocity (`raw_velocity`) that feeds the velocity IIR filter.
- Sits between the encoder pins and the BLDC velocity controller; it is the producer for both of that controller's feedback inputs.

Parameters:
- FILTER_DEPTH, 4: consecutive synchronized samples a pin must hold a new level before it is accepted; legal range 1..15.
- WINDOW_CYCLES, 1000: clock cycles per velocity measurement window; legal range 2..65535.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- enc_a  input  1  encoder channel A, asynchronous to clk
- enc_b  input  1  encoder channel B, asynchronous to clk
- enc_i  input  1  encoder index pulse, asynchronous to clk
- index_enable  input  1  when 1, an accepted index rising edge zeroes the count
- clear_error  input  1  synchronous clear of quad_error
- encoder_count  output  16  unsigned position count, wraps modulo 65536
- raw_velocity  output  13  signed two's-complement steps per window, saturated
- velocity_valid  output  1  one-cycle pulse when raw_velocity updates
- quad_error  output  1  sticky illegal-transition flag

Behaviour:
- Reset (async, active-high): all synchronizer, filter, counter and output registers go to 0. Outputs read encoder_count=0, raw_velocity=0, velocity_valid=0, quad_error=0. The filtered A/B/I state is 0 and the window counter is 0. Reset asserted mid-window discards the partial window.
- Synchronization: each of enc_a, enc_b, enc_i passes through 2 flops.
- Glitch filter: there is one filter per pin with its own 4-bit counter.
  - The counter increments each cycle the synchronized value differs from the filtered value.
  - The counter clears whenever the two values are equal.
  - The filtered value takes the new level on the cycle the counter would reach FILTER_DEPTH, and the counter then clears.
  - Pulses shorter than FILTER_DEPTH cycles are never accepted.
- Latency: a clean pin edge held stable appears on encoder_count exactly FILTER_DEPTH+3 rising clk edges after the first edge that samples it. That is 2 edges of sync, FILTER_DEPTH edges of filter, and 1 edge of count update.
- Decode compares the filtered {A,B} now against its value last cycle:
  - Forward sequence 00→10→11→01→00 gives a step of +1 (A leads B).
  - The reverse sequence gives −1.
  - No change gives 0.
  - A change of both bits in one cycle is illegal: step is 0, quad_error is set to 1, and the count is unchanged.
- encoder_count: count ← count + step, modulo 2^16. 65535 +1 → 0; 0 −1 → 65535.
- Index:
  - An accepted rising edge of filtered I while index_enable=1 sets encoder_count to 0 on that update edge.
  - This overrides any step in the same cycle.
  - That step is still accumulated for velocity.
  - When index_enable=0, index is ignored.
- quad_error: sticky. clear_error=1 clears it at the next edge. If an illegal transition and clear_error occur in the same cycle, set wins.
- Velocity accumulator:
  - Signed 17-bit register, saturating at ±65535, summing each cycle's step.
  - The window counter runs 0..WINDOW_CYCLES−1 and wraps.
  - On the terminal cycle (counter = WINDOW_CYCLES−1):
    - raw_velocity ← accumulator total including this cycle's step, saturated to [−4096, +4095];
    - velocity_valid=1 for that single cycle;
    - accumulator ← 0.
  - A step on the cycle after terminal counts in the new window. No step is lost or double-counted across the boundary.
- raw_velocity holds its value between windows. The first update occurs WINDOW_CYCLES cycles after reset deassertion.
- Illegal transitions contribute 0 to velocity.

Test Plan:
1. Clean forward stream: FILTER_DEPTH=4, 10 full cycles (40 edges) of A-leads-B, edges 20 clk apart, from reset → encoder_count=40. First change seen exactly 7 edges after the first enc_a sampling edge. quad_error=0.
2. Wrap and reverse: with the count at 0, apply 3 reverse edges → 65533. Then apply 5 forward edges → 2.
3. Glitch rejection: a 3-cycle pulse on enc_a with FILTER_DEPTH=4 → count unchanged. A 4-cycle pulse → count +1, then −1 when it drops after ≥4 stable cycles.
4. Velocity with WINDOW_CYCLES=100:
   - 25 forward steps inside one window → velocity_valid pulses once with raw_velocity=25.
   - Next window with 7 reverse steps → −7.
   - A step on the terminal cycle is included in the closing window.
5. Saturation: FILTER_DEPTH=1, WINDOW_CYCLES=20000, forward edges every 4 cycles (5000 steps/window) → raw_velocity=4095. The same rate reversed → −4096.
6. Index and error:
   - index_enable=1, index pulse at count 300 → 0, and later edges count from 0.
   - index_enable=0 → no effect.
   - A and B toggled in the same cycle → quad_error=1 and count held. clear_error → 0.
   - Assert reset mid-window → all outputs 0 immediately.
